// File: rtl/imem_loader.sv
// imem_loader: instruction memory with combinational fetch and a valid/ready program loader.
// Define LOAD_CKSUM_EN to verify a running checksum of the loaded words before signalling ld_done.
module imem_loader #(
    parameter int DATA_W = 16,
    parameter int ADDR_W = 8,
    parameter logic [DATA_W-1:0] NOP_WORD = '0
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] instr,
    output logic              cpu_hold,
    input  logic              ld_start,
    input  logic [ADDR_W-1:0] ld_base,
    input  logic [ADDR_W:0]   ld_count,
    input  logic              ld_valid,
    input  logic [DATA_W-1:0] ld_data,
    output logic              ld_ready,
    input  logic              ld_abort,
    output logic              ld_busy,
    output logic              ld_done,
    output logic              ld_err,
    input  logic [DATA_W-1:0] ld_cksum
);
    localparam logic [1:0] IDLE = 2'd0, LOAD = 2'd1, DONE = 2'd2;
    localparam logic [ADDR_W+1:0] DEPTH = (ADDR_W+2)'(2**ADDR_W);

    logic [DATA_W-1:0] mem [2**ADDR_W];
    logic [1:0] state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W:0] cnt_q, cnt_d;
    logic err_q, err_d;
    logic accept, req_bad, req_ok, sum_ok;

    assign accept = state_q == LOAD && ld_valid && !ld_abort;
    // Bounds are checked two bits wider than the address so base+count cannot wrap.
    assign req_bad = {1'b0, ld_count} > DEPTH || {2'b0, ld_base} + {1'b0, ld_count} > DEPTH;
    assign req_ok = state_q == IDLE && ld_start && !req_bad;

`ifdef LOAD_CKSUM_EN
    logic [DATA_W-1:0] sum_q, sum_d;
    assign sum_d = req_ok ? '0 : accept ? sum_q + ld_data : sum_q;
    assign sum_ok = sum_q == ld_cksum;
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) sum_q <= '0;
        else sum_q <= sum_d;
    end
`else
    logic unused_cksum;
    assign unused_cksum = ^ld_cksum;
    assign sum_ok = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        addr_d = addr_q;
        cnt_d = cnt_q;
        err_d = err_q;
        if (state_q == IDLE) begin
            if (ld_start && req_bad) err_d = 1'b1;
            else if (ld_start) begin
                err_d = 1'b0;
                addr_d = ld_base;
                cnt_d = ld_count;
                state_d = ld_count == '0 ? DONE : LOAD;
            end
        end else if (ld_abort) begin
            state_d = IDLE;
            err_d = 1'b1;
        end else if (state_q != LOAD) begin
            state_d = IDLE;
            err_d = err_q | !sum_ok;
        end else if (ld_valid) begin
            addr_d = addr_q + 1'b1;
            cnt_d = cnt_q - 1'b1;
            state_d = cnt_q == (ADDR_W+1)'(1) ? DONE : LOAD;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q <= IDLE;
            addr_q <= '0;
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            state_q <= state_d;
            addr_q <= addr_d;
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
    end

    // Contents deliberately survive reset so a partially loaded program is kept.
    always_ff @(posedge CLK) begin
        if (accept) mem[addr_q] <= ld_data;
    end

    assign ld_busy = state_q != IDLE;
    assign cpu_hold = ld_busy;
    assign ld_ready = state_q == LOAD;
    assign ld_done = state_q == DONE && !ld_abort && sum_ok;
    assign ld_err = err_q;
    assign instr = ld_busy ? NOP_WORD : mem[pc];
endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Parametrised instruction memory for the single-cycle CPU core, with an integrated program-loader FSM.
- Benches and the board-level debug path write programs through a valid/ready load port instead of forcing memory contents.
- The fetch port is combinational, so a single-cycle fetch still works.
- While a load is in progress the block holds the CPU and feeds it a NOP.

Parameters:
- DATA_W, 16, instruction word width in bits.
- ADDR_W, 8, address width; depth is 2**ADDR_W words.
- NOP_WORD, 16'h0000, word driven on instr while the CPU is held; width DATA_W.

Ports:
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  asynchronous active-high reset.
- pc  in  ADDR_W  fetch address from the CPU.
- instr  out  DATA_W  fetched instruction (combinational).
- cpu_hold  out  1  stall request to the CPU PC register.
- ld_start  in  1  one-cycle load request; sampled only in IDLE.
- ld_base  in  ADDR_W  first write address; sampled with ld_start.
- ld_count  in  ADDR_W+1  number of words to load; sampled with ld_start.
- ld_valid  in  1  ld_data is valid.
- ld_data  in  DATA_W  word to write.
- ld_ready  out  1  block accepts a word this cycle.
- ld_abort  in  1  cancel an active load.
- ld_busy  out  1  FSM is not in IDLE.
- ld_done  out  1  one-cycle pulse at successful completion.
- ld_err  out  1  sticky error flag; cleared by the next accepted ld_start or by RST.
- ld_cksum  in  DATA_W  expected checksum; used only when LOAD_CKSUM_EN is defined.

Behaviour:
- Reset values: all outputs 0 except instr, which is combinational; state IDLE; address and remaining-count registers 0.
- Memory contents are not cleared by RST.
- States: IDLE, LOAD, DONE.
- IDLE:
  - On ld_start, check the request: ld_count > 2**ADDR_W, or ld_base + ld_count > 2**ADDR_W (computed at ADDR_W+2 bits, so no wrap), is illegal.
  - Illegal request: set ld_err, stay in IDLE, write nothing.
  - ld_count == 0: go to DONE directly with no writes.
  - Otherwise: latch the address (= ld_base) and the remaining count (= ld_count), clear ld_err, go to LOAD.
- LOAD:
  - ld_ready = 1.
  - A word is accepted on the rising edge where ld_valid && ld_ready. The word is written to mem[addr]; addr is incremented and the remaining count decremented.
  - Acceptance of the last word goes to DONE on the following edge.
  - ld_valid low stalls with no change.
- DONE: lasts exactly one cycle; ld_done = 1; ld_ready = 0; next state IDLE.
- ld_abort in LOAD or DONE:
  - Go to IDLE on the next edge and set ld_err.
  - A word presented in the same cycle as ld_abort is not written.
  - Words already written are kept.
  - ld_abort in IDLE is ignored.
- ld_start while ld_busy is ignored.
- cpu_hold = ld_busy (asserted in LOAD and DONE). It falls the cycle after DONE, so the CPU resumes fetching in IDLE.
- instr:
  - cpu_hold = 1: instr = NOP_WORD.
  - Otherwise: instr = mem[pc], an asynchronous read with zero latency.
- Writes occur only in LOAD. There is no write port from the CPU.
- RST mid-load: immediately returns to IDLE and drops all outputs. Partial writes are kept; ld_err is cleared.

Optional Feature:
- Macro: LOAD_CKSUM_EN.
- Defined:
  - A DATA_W running checksum (modulo-2**DATA_W sum of accepted words) is cleared on the accepted ld_start.
  - On entering DONE, the checksum is compared with ld_cksum (sampled in the DONE cycle).
  - Mismatch: ld_done stays 0 and ld_err is set. Written data is not rolled back.
  - ld_count == 0 compares a checksum of 0.
- Undefined: there is no checksum logic, ld_cksum is ignored, and every completed load pulses ld_done.

Test Plan:
- Basic load:
  - Stimulus: RST, then ld_start with base 0, count 17; stream 16'h6000, 16'h7001, 16'h6017 … 16'h60A0 with ld_valid continuous.
  - Required: 17 writes in 17 cycles; ld_done pulse one cycle after the last word; cpu_hold high for 18 cycles.
  - Then: pc = 0..16 reads back the words; pc = 1 returns 16'h7001.
- Hold and backpressure:
  - Stimulus: ld_valid toggles 1,0,0,1 during a count-2 load; the CPU drives pc = 1.
  - Required: instr = NOP_WORD throughout; exactly 2 writes; ld_ready stays 1 in LOAD.
- Bounds:
  - Stimulus (ADDR_W = 8): ld_base = 250, ld_count = 7.
  - Required: ld_err = 1, ld_busy stays 0, mem[250..255] unchanged.
  - Then: ld_base = 249, ld_count = 7 succeeds and clears ld_err.
- Abort and reset mid-load:
  - Abort: ld_abort asserted after 3 of 8 words, with word 4 presented in the same cycle. Required: exactly 3 words written, ld_err = 1, IDLE next cycle.
  - Reset: RST asserted mid-load. Required: outputs drop to 0 asynchronously, before the next edge.
- Edge cases:
  - Stimulus: ld_count = 0.
  - Required: DONE one cycle later, ld_done pulse, no writes.
  - Stimulus: ld_start while busy.
  - Required: ignored; the current load completes unchanged.
- Checksum (LOAD_CKSUM_EN defined):
  - Stimulus: load 16'h0001, 16'hFFFF with ld_cksum = 16'h0000.
  - Required: ld_done pulse.
  - Stimulus: same load with ld_cksum = 16'h0001.
  - Required: ld_err = 1, no ld_done.
